// File: rtl/rvm_trap_seq.sv
// Trap sequencer: accepts exceptions, interrupts and MRET, sequences the
// mepc/mcause/mtval/mstatus updates and redirects the PC to the trap vector
// or the return address.
module rvm_trap_seq #(
  parameter int TRAP_ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_stall,
  input  logic        instr_retired,
  input  logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic [2:0]  irq_pending,
  input  logic        mret,
  input  logic [31:0] mepc,
  input  logic [29:0] mtvec,
  input  logic        mstatus_wen,
  input  logic [31:0] mstatus_wdata,
  output logic        trap_busy,
  output logic        mepc_wen,
  output logic [31:0] mepc_wdata,
  output logic        mcause_wen,
  output logic [31:0] mcause_wdata,
  output logic        mtval_wen,
  output logic [31:0] mtval_wdata,
  output logic        mstatus_mie,
  output logic        mstatus_mpie,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_addr
);

  typedef enum logic [1:0] {IDLE, SAVE, VECTOR, RETURN} state_t;

  localparam logic [31:0] VEC_MASK = ~((32'd1 << TRAP_ADDR_LSB) - 32'd1);

  state_t      state;
  state_t      state_next;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic        is_exc_q;
  logic [31:0] redirect_addr_q;
  logic        mie_q;
  logic        mpie_q;
  logic        take_exc;
  logic        take_irq;
  logic        take_mret;
  logic [3:0]  irq_code;
  logic [31:0] vector_addr;
  logic        unused_wdata_bits;

  assign vector_addr = {mtvec, 2'b00} & VEC_MASK;

  // Only MIE and MPIE of the mstatus write data matter; the rest is folded into a sink.
  assign unused_wdata_bits = ^{mstatus_wdata[31:8], mstatus_wdata[6:4], mstatus_wdata[2:0]};

  // Acceptance decision in IDLE: exception beats interrupt beats MRET.
  always_comb begin
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    irq_code  = 4'd0;
    if (state == IDLE && !core_stall) begin
      if (exc_valid)
        take_exc = 1'b1;
      else if (instr_retired && mie_q && irq_pending != 3'b000)
        take_irq = 1'b1;
      else if (mret)
        take_mret = 1'b1;
    end
    if (irq_pending[2])
      irq_code = 4'd11;
    else if (irq_pending[1])
      irq_code = 4'd3;
    else if (irq_pending[0])
      irq_code = 4'd7;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic and strobes decoded from the current state.
  always_comb begin
    state_next  = state;
    mepc_wen    = 1'b0;
    mcause_wen  = 1'b0;
    mtval_wen   = 1'b0;
    pc_redirect = 1'b0;
    trap_busy   = 1'b1;
    case (state)
      IDLE: begin
        trap_busy = 1'b0;
        if (take_exc || take_irq)
          state_next = SAVE;
        else if (take_mret)
          state_next = RETURN;
      end
      SAVE: begin
        mepc_wen   = 1'b1;
        mcause_wen = 1'b1;
        mtval_wen  = is_exc_q;
        state_next = VECTOR;
      end
      VECTOR: begin
        pc_redirect = 1'b1;
        state_next  = IDLE;
      end
      RETURN: begin
        pc_redirect = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch trap information on acceptance and register the redirect target one cycle ahead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_q         <= 32'd0;
      epc_q           <= 32'd0;
      tval_q          <= 32'd0;
      is_exc_q        <= 1'b0;
      redirect_addr_q <= 32'd0;
    end else begin
      if (take_exc) begin
        epc_q    <= pc;
        cause_q  <= {28'd0, exc_cause};
        tval_q   <= exc_tval;
        is_exc_q <= 1'b1;
      end else if (take_irq) begin
        epc_q    <= next_pc;
        cause_q  <= {1'b1, 27'd0, irq_code};
        tval_q   <= 32'd0;
        is_exc_q <= 1'b0;
      end
      case (state_next)
        VECTOR:  redirect_addr_q <= vector_addr;
        RETURN:  redirect_addr_q <= mepc;
        default: redirect_addr_q <= 32'd0;
      endcase
    end
  end

  // mstatus interrupt-enable bits; trap and return updates take precedence over CSR writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else if (state == SAVE) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (state == RETURN) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (mstatus_wen) begin
      mie_q  <= mstatus_wdata[3];
      mpie_q <= mstatus_wdata[7];
    end
  end

  assign mepc_wdata       = epc_q;
  assign mcause_wdata     = cause_q;
  assign mtval_wdata      = tval_q;
  assign mstatus_mie      = mie_q;
  assign mstatus_mpie     = mpie_q;
  assign pc_redirect_addr = redirect_addr_q;

endmodule
